// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed seven-segment driver with a double-buffered display word.
// The shadow word only changes on the digit-7 -> digit-0 wrap, so a frame never mixes two words.
`timescale 1ns/1ps
module seg7_scan_driver #(
  parameter int unsigned CLK_DIV  = 50000,
  parameter int unsigned LZ_BLANK = 0
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        i_we,
  input  logic [31:0] i_data,
  output logic [31:0] o_value,
  output logic [7:0]  o_seg,
  output logic [7:0]  o_sel
);

  localparam int unsigned    DW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

  logic [31:0]   value_reg;
  logic [31:0]   shadow;
  logic          pending;
  logic [DW-1:0] div_cnt;
  logic [2:0]    idx;
  logic          tick;
  logic          frame_end;
  logic [3:0]    nibble;
  logic          blank;
  logic [7:0]    seg_next;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;
      4'h1: return 8'hF9;
      4'h2: return 8'hA4;
      4'h3: return 8'hB0;
      4'h4: return 8'h99;
      4'h5: return 8'h92;
      4'h6: return 8'h82;
      4'h7: return 8'hF8;
      4'h8: return 8'h80;
      4'h9: return 8'h90;
      4'hA: return 8'h88;
      4'hB: return 8'h83;
      4'hC: return 8'hC6;
      4'hD: return 8'hA1;
      4'hE: return 8'h86;
      default: return 8'h8E;
    endcase
  endfunction

  always_comb begin
    tick      = (div_cnt == DIV_LAST);
    frame_end = tick && (idx == 3'd7);
    nibble    = shadow[{idx, 2'b00} +: 4];
    // Digit k is blank when it and every digit to its left are zero; digit 0 always shows.
    blank     = (LZ_BLANK != 0) && (idx != 3'd0) && ((shadow >> {idx, 2'b00}) == '0);
    seg_next  = blank ? 8'hFF : hex_to_seg(nibble);
  end

  assign o_value = value_reg;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      value_reg <= '0;
      shadow    <= '0;
      pending   <= 1'b0;
      div_cnt   <= '0;
      idx       <= '0;
      o_seg     <= '1;
      o_sel     <= '1;
    end else begin
      if (i_we)
        value_reg <= i_data;
      // A write on the wrap edge keeps pending set: the shadow takes the old word,
      // and the new one goes up a frame later.
      pending <= i_we | (pending & ~frame_end);
      if (frame_end && pending)
        shadow <= value_reg;
      if (tick) begin
        div_cnt <= '0;
        idx     <= idx + 3'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      o_sel <= ~(8'b1 << idx);
      o_seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: two instances (blanking off/on) share stimulus,
// and per-edge expected select/segment values are queued frame by frame.
`timescale 1ns/1ps
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_we = 1'b0;
  logic [31:0] i_data = '0;
  logic [31:0] value, value_lz;
  logic [7:0]  seg, sel, seg_lz, sel_lz;

  int checks = 0;
  int errors = 0;
  int n;

  typedef struct {
    int         cyc;
    logic [7:0] sel;
    logic [7:0] seg;
    logic [7:0] seg_lz;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg7_scan_driver #(.CLK_DIV(4), .LZ_BLANK(0)) dut (
    .clk_in(clk), .reset(reset), .i_we(i_we), .i_data(i_data),
    .o_value(value), .o_seg(seg), .o_sel(sel)
  );

  seg7_scan_driver #(.CLK_DIV(4), .LZ_BLANK(1)) dut_lz (
    .clk_in(clk), .reset(reset), .i_we(i_we), .i_data(i_data),
    .o_value(value_lz), .o_seg(seg_lz), .o_sel(sel_lz)
  );

  always #10 clk = ~clk;

  // Edges since reset was released; edge 1 is the first output update.
  always @(posedge clk or posedge reset) begin
    if (reset) n <= 0;
    else       n <= n + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h edge=%0d", tag, got, exp, n);
    end
  endtask

  // Queue the 32 edges of the frame following edge `base`, showing word w.
  task automatic expect_frame(input int base, input logic [31:0] w);
    exp_t       e;
    logic [3:0] nib;
    for (int d = 0; d < 8; d++) begin
      for (int c = 1; c <= 4; c++) begin
        e.cyc    = base + d * 4 + c;
        e.sel    = ~(8'h01 << d);
        nib      = w[d * 4 +: 4];
        e.seg    = seg_tab[nib];
        e.seg_lz = (d > 0 && (w >> (d * 4)) == 32'h0) ? 8'hFF : e.seg;
        sb.push_back(e);
      end
    end
  endtask

  // Drive a write that is captured on edge e.
  task automatic write_at(input int e, input logic [31:0] d);
    while (n < e - 1) @(negedge clk);
    i_we   = 1'b1;
    i_data = d;
    @(negedge clk);
    i_we = 1'b0;
    check("value", value, d);
    check("value_lz", value_lz, d);
  endtask

  task automatic check_blank(input string tag);
    check({tag, "_sel"}, {24'h0, sel}, 32'hFF);
    check({tag, "_seg"}, {24'h0, seg}, 32'hFF);
    check({tag, "_sel_lz"}, {24'h0, sel_lz}, 32'hFF);
    check({tag, "_seg_lz"}, {24'h0, seg_lz}, 32'hFF);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= n) begin
      mon_e = sb.pop_front();
      if (mon_e.cyc < n) begin
        check("sb_miss", n, mon_e.cyc);
      end else begin
        check("sel", {24'h0, sel}, {24'h0, mon_e.sel});
        check("seg", {24'h0, seg}, {24'h0, mon_e.seg});
        check("sel_lz", {24'h0, sel_lz}, {24'h0, mon_e.sel});
        check("seg_lz", {24'h0, seg_lz}, {24'h0, mon_e.seg_lz});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", n, 66);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held ~2.25 cycles; outputs blank throughout.
    #1 reset = 1'b1;
    #14 check_blank("rst_hold");
    #31 reset = 1'b0;
    check_blank("rst_release");
    check("value_rst", value, 32'h0);
    expect_frame(0, 32'h0);

    // Full-word decode, shown from the frame after the next wrap.
    write_at(6, 32'h89ABCDEF);
    expect_frame(32, 32'h89ABCDEF);

    // Mid-frame write while idx==3 must not tear the frame being shown.
    write_at(45, 32'h11111111);
    expect_frame(64, 32'h11111111);
    expect_frame(96, 32'h11111111);

    // Pending 0, then a write exactly on the wrap edge: 0 shows next, 5 the frame after.
    write_at(100, 32'h0);
    expect_frame(128, 32'h0);
    write_at(128, 32'h00000005);
    expect_frame(160, 32'h00000005);

    // Leading-zero patterns.
    write_at(170, 32'h00000120);
    expect_frame(192, 32'h00000120);
    write_at(200, 32'h0);
    expect_frame(224, 32'h0);

    // Pending word discarded by a mid-frame reset at idx==5.
    write_at(230, 32'hAAAAAAAA);
    while (n < 245) @(negedge clk);
    #4 reset = 1'b1;
    sb.delete();
    #2 check_blank("rst_mid");
    check("value_mid", value, 32'h0);
    check("value_mid_lz", value_lz, 32'h0);
    #2 reset = 1'b0;
    #1 check_blank("rst_mid_release");
    expect_frame(0, 32'h0);
    expect_frame(32, 32'h0);

    while (n < 66) @(negedge clk);
    check("sb_drain", sb.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
